// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and next-state table builder for the serial pattern detector
package seq_det_pkg;

  localparam int MAX_PAT_W = 32;

  // Longest j < width where the first j pattern bits equal the last j bits of the string
  // formed by the first `state` pattern bits followed by b (the whole pattern on a match).
  function automatic int next_state(input logic [MAX_PAT_W-1:0] pattern, input int width,
                                    input logic b, input int state, input logic ovl);
    logic [MAX_PAT_W:0] s;
    int len;
    int best;
    logic ok;
    logic is_match;
    s = '0;
    best = 0;
    is_match = (state == width - 1) && (b == pattern[0]);
    if (is_match) begin
      len = width;
      for (int i = 0; i < MAX_PAT_W; i++)
        if (i < width) s[i] = pattern[width-1-i];
    end else begin
      len = state + 1;
      for (int i = 0; i < MAX_PAT_W; i++)
        if (i < state) s[i] = pattern[width-1-i];
      s[state] = b;
    end
    if (!(is_match && !ovl)) begin
      for (int j = 1; j < MAX_PAT_W; j++) begin
        if (j < width && j <= len) begin
          ok = 1'b1;
          for (int i = 0; i < MAX_PAT_W; i++)
            if (i < j && s[len-j+i] != pattern[width-1-i]) ok = 1'b0;
          if (ok) best = j;
        end
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter with priority synchronous clear
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/param_seq_detector.sv
// rtl/param_seq_detector.sv - Mealy serial pattern detector with table-driven next state
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int               CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     inp,
  input  logic                     ovl,
  input  logic                     cnt_clr,
  output logic                     y,
  output logic                     y_q,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [$clog2(PAT_W)-1:0] state
);

  localparam int             SW   = $clog2(PAT_W);
  localparam logic [SW-1:0]  LAST = SW'(PAT_W - 1);

  logic [SW-1:0] nxt_tbl [PAT_W][2][2];
  logic [SW-1:0] state_nxt;

  // Table indexed [state][bit][ovl], fully resolved at elaboration.
  for (genvar k = 0; k < PAT_W; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      for (genvar o = 0; o < 2; o++) begin : g_ovl
        localparam int NS = next_state(MAX_PAT_W'(PATTERN), PAT_W, 1'(b), k, 1'(o));
        assign nxt_tbl[k][b][o] = NS[SW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    y         = 1'b0;
    if (en) begin
      if (32'(state) < PAT_W)
        state_nxt = nxt_tbl[state][inp][ovl];
      else
        state_nxt = '0;
      y = rst && (state == LAST) && (inp == PATTERN[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= '0;
      y_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      y_q   <= y;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (y),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

endmodule

// File: tb/tb_param_seq_detector.sv
// tb/tb_param_seq_detector.sv - scoreboard bench for param_seq_detector across three configurations
module tb_param_seq_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, en = 1'b0, inp = 1'b0, ovl = 1'b0, cnt_clr = 1'b0;

  logic       ya, yqa, yb, yqb, yc, yqc;
  logic [7:0] cnta, cntc;
  logic [1:0] cntb, sta, stb;
  logic [2:0] stc;

  param_seq_detector #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .inp(inp), .ovl(ovl), .cnt_clr(cnt_clr),
    .y(ya), .y_q(yqa), .match_cnt(cnta), .state(sta));
  param_seq_detector #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .inp(inp), .ovl(ovl), .cnt_clr(cnt_clr),
    .y(yb), .y_q(yqb), .match_cnt(cntb), .state(stb));
  param_seq_detector #(.PAT_W(8), .PATTERN(8'b11011011), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .en(en), .inp(inp), .ovl(ovl), .cnt_clr(cnt_clr),
    .y(yc), .y_q(yqc), .match_cnt(cntc), .state(stc));

  int act_y [3], act_yq [3], act_cnt [3], act_st [3];
  always_comb begin
    act_y[0] = int'(ya);  act_yq[0] = int'(yqa); act_cnt[0] = int'(cnta); act_st[0] = int'(sta);
    act_y[1] = int'(yb);  act_yq[1] = int'(yqb); act_cnt[1] = int'(cntb); act_st[1] = int'(stb);
    act_y[2] = int'(yc);  act_yq[2] = int'(yqc); act_cnt[2] = int'(cntc); act_st[2] = int'(stc);
  end

  // Reference: bit history since the last reset / non-overlapping match.
  logic [31:0] pat  [3] = '{32'b1010, 32'b1010, 32'b11011011};
  int          pw   [3] = '{4, 4, 8};
  int          cmax [3] = '{255, 3, 255};
  logic [63:0] hist [3];
  int          hlen [3];
  int          mcnt [3];

  typedef struct {int inst; int yq; int cnt; int st;} exp_t;
  exp_t sbq [$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic suffix_is_prefix(input int i, input int j);
    logic ok = 1'b1;
    if (j > hlen[i]) return 1'b0;
    for (int t = 0; t < j; t++)
      if (hist[i][j-1-t] != pat[i][pw[i]-1-t]) ok = 1'b0;
    return ok;
  endfunction

  function automatic int model_state(input int i);
    int best = 0;
    for (int j = 1; j < pw[i]; j++)
      if (suffix_is_prefix(i, j)) best = j;
    return best;
  endfunction

  task automatic step(input logic e, input logic b, input logic o, input logic c, input string tag);
    int   ey [3];
    exp_t x;
    @(negedge clk);
    en = e; inp = b; ovl = o; cnt_clr = c;
    for (int i = 0; i < 3; i++) begin
      ey[i] = 0;
      if (e) begin
        hist[i] = {hist[i][62:0], b};
        if (hlen[i] < 64) hlen[i]++;
        if (suffix_is_prefix(i, pw[i])) begin
          ey[i] = 1;
          if (!o) hlen[i] = 0;
        end
      end
      if (c) mcnt[i] = 0;
      else if (ey[i] == 1 && mcnt[i] < cmax[i]) mcnt[i]++;
      x.inst = i; x.yq = ey[i]; x.cnt = mcnt[i]; x.st = model_state(i);
      sbq.push_back(x);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (act_y[i] !== ey[i]) begin
        n_fail++;
        $display("FAIL %s inst%0d y: got %0d expected %0d", tag, i, act_y[i], ey[i]);
      end
    end
    @(posedge clk); #1;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      n_tests++;
      if (act_yq[x.inst] !== x.yq || act_cnt[x.inst] !== x.cnt || act_st[x.inst] !== x.st) begin
        n_fail++;
        $display("FAIL %s inst%0d y_q/cnt/state: got %0d/%0d/%0d expected %0d/%0d/%0d", tag, x.inst,
                 act_yq[x.inst], act_cnt[x.inst], act_st[x.inst], x.yq, x.cnt, x.st);
      end
    end
  endtask

  task automatic test_reset(input string tag);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; inp = 1'b0; ovl = 1'b1; cnt_clr = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (act_y[i] !== 0) begin
        n_fail++;
        $display("FAIL %s inst%0d y during reset: got %0d expected 0", tag, i, act_y[i]);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      hlen[i] = 0; mcnt[i] = 0;
      n_tests++;
      if (act_st[i] !== 0 || act_yq[i] !== 0 || act_cnt[i] !== 0) begin
        n_fail++;
        $display("FAIL %s inst%0d after reset state/y_q/cnt: got %0d/%0d/%0d expected 0/0/0",
                 tag, i, act_st[i], act_yq[i], act_cnt[i]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic feed(input logic [31:0] bits, input int n, input logic o, input string tag);
    for (int k = n - 1; k >= 0; k--) step(1'b1, bits[k], o, 1'b0, tag);
  endtask

  task automatic check_cnt(input int i, input int want, input string tag);
    n_tests++;
    if (act_cnt[i] !== want) begin
      n_fail++;
      $display("FAIL %s inst%0d match_cnt: got %0d expected %0d", tag, i, act_cnt[i], want);
    end
  endtask

  task automatic test_overlap();
    test_reset("ovl_rst");
    feed(32'b10101010, 8, 1'b1, "ovl");
    check_cnt(0, 3, "ovl_total");
  endtask

  task automatic test_non_overlap();
    test_reset("novl_rst");
    feed(32'b10101010, 8, 1'b0, "novl");
    check_cnt(0, 2, "novl_total");
  endtask

  task automatic test_enable_gap();
    test_reset("gap_rst");
    feed(32'b101, 3, 1'b1, "gap_pre");
    for (int k = 0; k < 3; k++) step(1'b0, k[0], 1'b1, 1'b0, "gap_idle");
    step(1'b1, 1'b0, 1'b1, 1'b0, "gap_last");
    check_cnt(0, 1, "gap_total");
  endtask

  task automatic test_saturate();
    test_reset("sat_rst");
    feed(32'b101010101010, 12, 1'b1, "sat");
    check_cnt(1, 3, "sat_hold");
    step(1'b1, 1'b1, 1'b1, 1'b0, "sat_clr");
    step(1'b1, 1'b0, 1'b1, 1'b1, "sat_clr");
    check_cnt(1, 0, "sat_clr_wins");
  endtask

  task automatic test_mid_reset();
    test_reset("mid_rst0");
    feed(32'b101, 3, 1'b1, "mid_pre");
    test_reset("mid_rst");
    step(1'b1, 1'b0, 1'b1, 1'b0, "mid_post");
  endtask

  task automatic test_long_pattern();
    test_reset("long_rst");
    feed(32'b11011011011, 11, 1'b1, "long");
    check_cnt(2, 2, "long_total");
  endtask

  task automatic test_random();
    test_reset("rnd_rst");
    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0, "rnd");
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin hist[i] = '0; hlen[i] = 0; mcnt[i] = 0; end
    test_overlap();
    test_non_overlap();
    test_enable_gap();
    test_saturate();
    test_mid_reset();
    test_long_pattern();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
